// File: rtl/kyber_barrett_reduce_pkg.sv
// Shared Kyber arithmetic constants and types, used by the Barrett reducer,
// NTT butterflies and modular adder stages.
package kyber_barrett_reduce_pkg;

    localparam int unsigned KyberQ   = 3329;
    localparam int unsigned BarrettK = 26;
    localparam int unsigned BarrettM = 20158;
    localparam int unsigned CoefW    = 12;
    localparam int unsigned RedW     = CoefW + 1;
    localparam int unsigned ProdW    = 32;
    localparam int unsigned XW       = 24;

    typedef logic [CoefW-1:0] coef_t;
    typedef logic [RedW-1:0]  red_t;

    // Products wider than 24 bits come from a misbehaving multiplier stage.
    function automatic logic prod_ovf(input logic [ProdW-1:0] prod);
        return |prod[ProdW-1:XW];
    endfunction

endpackage

// File: rtl/kyber_barrett_reduce_if.sv
// Valid/ready stream bundle for the Barrett reducer: product beats in, coefficients out.
interface kyber_barrett_reduce_if #(
    parameter int unsigned IDXW = 8
);
    import kyber_barrett_reduce_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ProdW-1:0]  in_prod;
    logic [IDXW-1:0]   in_idx;
    logic              out_valid;
    logic              out_ready;
    coef_t             out_coef;
    logic [IDXW-1:0]   out_idx;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_idx, out_ready,
        input  in_ready, out_valid, out_coef, out_idx, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_idx, out_ready,
        output in_ready, out_valid, out_coef, out_idx, out_ovf
    );

endinterface

// File: rtl/barrett_csub.sv
// Conditional subtraction of Q: maps a value in [0, 2Q) onto [0, Q).
module barrett_csub
    import kyber_barrett_reduce_pkg::*;
#(
    parameter int unsigned Q = KyberQ
) (
    input  red_t  a_i,
    output coef_t r_o
);

    red_t diff;

    always_comb begin
        diff = a_i - RedW'(Q);
        r_o  = (a_i >= RedW'(Q)) ? CoefW'(diff) : CoefW'(a_i);
    end

endmodule

// File: rtl/kyber_barrett_reduce.sv
// Three-stage Barrett reduction of a 24-bit product modulo Q with a
// whole-pipe stall on output backpressure.
module kyber_barrett_reduce
    import kyber_barrett_reduce_pkg::*;
#(
    parameter int unsigned Q    = KyberQ,
    parameter int unsigned K    = BarrettK,
    parameter int unsigned M    = BarrettM,
    parameter int unsigned IDXW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kyber_barrett_reduce_if.slave bus,
    output logic                  busy
);

    localparam int unsigned PW  = XW + 15;
    localparam int unsigned TQW = 25;

    logic en;

    logic            v1_q, v1_d, ovf1_q, ovf1_d;
    logic [XW-1:0]   x1_q, x1_d;
    logic [PW-1:0]   p1_q, p1_d;
    logic [IDXW-1:0] idx1_q, idx1_d;

    logic            v2_q, v2_d, ovf2_q, ovf2_d;
    logic [XW-1:0]   x2_q, x2_d;
    logic [TQW-1:0]  tq2_q, tq2_d;
    logic [IDXW-1:0] idx2_q, idx2_d;

    logic            v3_q, v3_d, ovf3_q, ovf3_d;
    coef_t           coef3_q, coef3_d;
    logic [IDXW-1:0] idx3_q, idx3_d;

    red_t  t2, r3;
    coef_t coef_red;

    barrett_csub #(
        .Q (Q)
    ) u_csub (
        .a_i (r3),
        .r_o (coef_red)
    );

    always_comb begin
        en = !v3_q || bus.out_ready;
        t2 = RedW'(p1_q >> K);
        // Barrett guarantees x - t*Q lies in [0, 2Q), so 13 low bits are exact.
        r3 = RedW'(x2_q) - RedW'(tq2_q);

        v1_d    = v1_q;
        x1_d    = x1_q;
        p1_d    = p1_q;
        idx1_d  = idx1_q;
        ovf1_d  = ovf1_q;
        v2_d    = v2_q;
        x2_d    = x2_q;
        tq2_d   = tq2_q;
        idx2_d  = idx2_q;
        ovf2_d  = ovf2_q;
        v3_d    = v3_q;
        coef3_d = coef3_q;
        idx3_d  = idx3_q;
        ovf3_d  = ovf3_q;

        if (en) begin
            v1_d    = bus.in_valid;
            x1_d    = bus.in_prod[XW-1:0];
            p1_d    = PW'(x1_d) * PW'(M);
            idx1_d  = bus.in_idx;
            ovf1_d  = prod_ovf(bus.in_prod);

            v2_d    = v1_q;
            x2_d    = x1_q;
            tq2_d   = TQW'(t2) * TQW'(Q);
            idx2_d  = idx1_q;
            ovf2_d  = ovf1_q;

            v3_d    = v2_q;
            coef3_d = coef_red;
            idx3_d  = idx2_q;
            ovf3_d  = ovf2_q;
        end
    end

    always_comb begin
        bus.in_ready  = en;
        bus.out_valid = v3_q;
        bus.out_coef  = coef3_q;
        bus.out_idx   = idx3_q;
        bus.out_ovf   = ovf3_q;
        busy          = v1_q || v2_q || v3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            x1_q    <= '0;
            p1_q    <= '0;
            idx1_q  <= '0;
            ovf1_q  <= 1'b0;
            v2_q    <= 1'b0;
            x2_q    <= '0;
            tq2_q   <= '0;
            idx2_q  <= '0;
            ovf2_q  <= 1'b0;
            v3_q    <= 1'b0;
            coef3_q <= '0;
            idx3_q  <= '0;
            ovf3_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            x1_q    <= x1_d;
            p1_q    <= p1_d;
            idx1_q  <= idx1_d;
            ovf1_q  <= ovf1_d;
            v2_q    <= v2_d;
            x2_q    <= x2_d;
            tq2_q   <= tq2_d;
            idx2_q  <= idx2_d;
            ovf2_q  <= ovf2_d;
            v3_q    <= v3_d;
            coef3_q <= coef3_d;
            idx3_q  <= idx3_d;
            ovf3_q  <= ovf3_d;
        end
    end

endmodule

// File: doc/kyber_barrett_reduce.md
KYBER_BARRETT_REDUCE -- requirements
Module: kyber_barrett_reduce

Interface
REQ-001 Parameter Q, default 3329, Kyber modulus.
REQ-002 Parameter K, default 26, Barrett shift amount.
REQ-003 Parameter M, default 20158, Barrett constant floor(2^K/Q).
REQ-004 Parameter IDXW, default 8, coefficient index width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  input beat offered.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_prod  input  32  unsigned product from the 16x16 multiplier stage.
REQ-010 in_idx  input  IDXW  coefficient index, carried unchanged.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_coef  output  12  in_prod mod Q, range 0..Q-1.
REQ-014 out_idx  output  IDXW  index of the beat on out_coef.
REQ-015 out_ovf  output  1  in_prod[31:24] was nonzero for this beat.
REQ-016 busy  output  1  OR of all stage valid bits.

Function
REQ-017 Transfer in: in_valid&&in_ready; transfer out: out_valid&&out_ready.
REQ-018 Three-stage pipeline with per-stage valid bits v1,v2,v3 and a global advance en = !v3 || out_ready; in_ready = en (combinational, no dependence on in_valid).
REQ-019 Stage 1 (on en): register x = in_prod[23:0], idx, ovf = |in_prod[31:24], p = x*M (39 bits), v1 = in_valid.
REQ-020 Stage 2 (on en): t = p>>K (13 bits), register tq = t*Q (25 bits), x, idx, ovf, v2 = v1.
REQ-021 Stage 3 (on en): r = x - tq (13-bit, guaranteed 0 <= r < 2Q); out_coef = (r >= Q) ? r-Q : r; register with idx, ovf, v3 = v2.
REQ-022 Latency: exactly 3 cycles from input transfer to out_valid when out_ready held high; throughput 1 beat/cycle.
REQ-023 When en = 0, every stage register including valid bits holds; no beat lost, duplicated or reordered.
REQ-024 Bubbles are not collapsed; a stall freezes the whole pipe.
REQ-025 out_coef, out_idx, out_ovf stable while out_valid && !out_ready.
REQ-026 Out-of-range input (bits 31:24 nonzero): result is in_prod[23:0] mod Q, out_ovf = 1; no other effect.
REQ-027 Simultaneous output transfer and input transfer in the same cycle is legal and sustains full rate.

Reset
REQ-028 rst_n low clears v1,v2,v3 immediately (asynchronously); out_valid = 0, busy = 0, in_ready = 1 while in reset.
REQ-029 Data registers reset to 0; out_coef = 0, out_idx = 0, out_ovf = 0.
REQ-030 Reset mid-operation discards all in-flight beats; first beat after release has latency per REQ-022.

Structure
REQ-031 Q, K, M and the 12-bit coefficient width belong in the shared Kyber package, used also by NTT and adder stages.
REQ-032 One sub-module, barrett_csub: combinational 13-bit conditional subtract of Q, reused by the modular adder.
REQ-033 Multiplications use behavioural operators; no vendor primitives.

Verification
REQ-034 in_prod = 0, 3329, 6657 back-to-back, out_ready = 1 -> out_coef 0, 0, 3328 on cycles 3, 4, 5 after the first transfer.
REQ-035 in_prod = 11075584 (3328*3328) -> out_coef = 1; in_prod = 16777215 -> out_coef = 2384, out_ovf = 0.
REQ-036 in_prod = 0x01000000 -> out_coef = 0, out_ovf = 1.
REQ-037 Stream idx 0..7 with out_ready low for cycles 4..8 -> in_ready low during the stall, all 8 results delivered in order with correct out_idx, none duplicated.
REQ-038 rst_n pulsed low with 3 beats in flight -> out_valid drops in the same cycle, busy = 0, no stale beat appears after release.
REQ-039 Random 10^5 beats with random in_valid/out_ready, in_prod < 2^24 -> every out_coef equals reference in_prod mod 3329.
